// File: rtl/dqm_pkg.sv
// rtl/dqm_pkg.sv - shared constants and state encoding for the DQM deframer
package dqm_pkg;

   // Header layout: two sync words followed by one quality word
   localparam int SYNC_WIDTH = 32;
   localparam int DQM_WIDTH  = 16;
   localparam int HDR_LEN    = SYNC_WIDTH + DQM_WIDTH;

   // Deframer state enumeration, kept as plain constants for legacy tools
   typedef logic [1:0] state_t;
   localparam state_t ST_SEARCH  = 2'd0;
   localparam state_t ST_DQM     = 2'd1;
   localparam state_t ST_PAYLOAD = 2'd2;
   localparam state_t ST_CHECK   = 2'd3;

endpackage

// File: rtl/dqm_deframer_bit_packer.sv
// rtl/dqm_deframer_bit_packer.sv - 8-bit MSB-first serial-to-parallel packer with flush on last
module dqm_bit_packer (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_in,
   input  logic       bit_en,
   input  logic       last,
   output logic [7:0] byte_out,
   output logic       byte_valid
);

   logic [7:0] acc;
   logic [7:0] acc_nxt;
   logic [2:0] pos;

   // Place the incoming bit at its MSB-first position in the accumulator
   always_comb begin
      acc_nxt = acc;
      acc_nxt[3'd7 - pos] = bit_in;
   end

   // Emit on the 8th bit or on the frame's last bit (left-justified, zero-padded)
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         pos        <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (bit_en) begin
            if (pos == 3'd7 || last) begin
               byte_out   <= acc_nxt;
               byte_valid <= 1'b1;
               acc        <= '0;
               pos        <= '0;
            end else begin
               acc <= acc_nxt;
               pos <= pos + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/dqm_deframer.sv
// rtl/dqm_deframer.sv - serial DQM frame sync search, flywheel lock and payload unpacking
module dqm_deframer
   import dqm_pkg::*;
#(
   parameter int MISS_LIMIT = 3,
   parameter int SYNC_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bit_in,
   input  logic                  bit_en,
   input  logic [SYNC_WIDTH-1:0] sync_word,
   input  logic [15:0]           block_size,
   output logic [DQM_WIDTH-1:0]  dqm_word,
   output logic                  dqm_valid,
   output logic [7:0]            byte_out,
   output logic                  byte_valid,
   output logic                  frame_start,
   output logic                  locked,
   output logic [15:0]           frame_count
);

   state_t                state;
   logic [SYNC_WIDTH-1:0] sync_sr;
   logic [SYNC_WIDTH-1:0] cand;
   logic [15:0]           cnt;
   logic [15:0]           blk_lat;
   logic [7:0]            miss;
   logic                  pk_en;
   logic                  pk_last;

   // Window including the bit being accepted this cycle
   assign cand    = {sync_sr[SYNC_WIDTH-2:0], bit_in};
   assign pk_en   = bit_en && (state == ST_PAYLOAD);
   assign pk_last = (cnt == blk_lat - 16'd1);

   // Frame state machine: search, header, payload count, and sync check with flywheel
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_SEARCH;
         sync_sr     <= '0;
         cnt         <= '0;
         blk_lat     <= '0;
         miss        <= '0;
         dqm_word    <= '0;
         dqm_valid   <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         frame_count <= '0;
      end else begin
         dqm_valid   <= 1'b0;
         frame_start <= 1'b0;
         if (bit_en) begin
            sync_sr <= cand;
            case (state)
               ST_SEARCH: begin
                  if (cand == sync_word) begin
                     state       <= ST_DQM;
                     cnt         <= '0;
                     blk_lat     <= block_size;
                     frame_start <= 1'b1;
                  end
               end
               ST_DQM: begin
                  if (cnt == 16'(DQM_WIDTH - 1)) begin
                     dqm_word  <= cand[DQM_WIDTH-1:0];
                     dqm_valid <= 1'b1;
                     cnt       <= '0;
                     state     <= (blk_lat == 16'd0) ? ST_CHECK : ST_PAYLOAD;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               ST_PAYLOAD: begin
                  if (pk_last) begin
                     cnt   <= '0;
                     state <= ST_CHECK;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               default: begin
                  if (cnt == 16'(SYNC_WIDTH - 1)) begin
                     cnt <= '0;
                     if (cand == sync_word) begin
                        locked      <= 1'b1;
                        miss        <= '0;
                        frame_count <= frame_count + 16'd1;
                        state       <= ST_DQM;
                        blk_lat     <= block_size;
                        frame_start <= 1'b1;
                     end else if (miss != 8'(MISS_LIMIT - 1)) begin
                        miss        <= miss + 8'd1;
                        state       <= ST_DQM;
                        blk_lat     <= block_size;
                        frame_start <= 1'b1;
                     end else begin
                        locked <= 1'b0;
                        miss   <= '0;
                        state  <= ST_SEARCH;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
            endcase
         end
      end
   end

   dqm_bit_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_en     (pk_en),
      .last       (pk_last),
      .byte_out   (byte_out),
      .byte_valid (byte_valid)
   );

endmodule

// File: tb/tb_dqm_deframer.sv
// tb/tb_dqm_deframer.sv - directed table-driven bench for dqm_deframer
module tb_dqm_deframer;

   localparam logic [31:0] W = 32'hFAF3_3400;
   localparam logic [31:0] C = 32'hFAF3_3401;

   logic        clk = 1'b0;
   logic        rst;
   logic        bit_in;
   logic        bit_en;
   logic [31:0] sync_word;
   logic [15:0] block_size;
   logic [15:0] dqm_word;
   logic        dqm_valid;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        frame_start;
   logic        locked;
   logic [15:0] frame_count;

   typedef struct {
      logic [31:0] sync;
      logic [15:0] dqm;
      logic [15:0] bs;
      logic [31:0] payload;
      logic        gap;
      int          exp_fs;
      int          exp_dv;
      int          exp_nb;
      logic [31:0] exp_bytes;
      logic        exp_locked;
      logic [15:0] exp_fc;
   } vec_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         fs_cnt  = 0;
   int         viol    = 0;
   logic       en_at_edge;
   logic [7:0] byte_log[$];
   logic [15:0] dqm_log[$];
   vec_t       tbl[11];

   always #5 clk = ~clk;

   dqm_deframer #(.MISS_LIMIT(3), .SYNC_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_in      (bit_in),
      .bit_en      (bit_en),
      .sync_word   (sync_word),
      .block_size  (block_size),
      .dqm_word    (dqm_word),
      .dqm_valid   (dqm_valid),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .frame_start (frame_start),
      .locked      (locked),
      .frame_count (frame_count)
   );

   // Record pulses shortly after each edge and flag any pulse not caused by an enabled bit
   always begin
      @(posedge clk);
      en_at_edge = bit_en;
      #1;
      if (frame_start) fs_cnt++;
      if (dqm_valid) dqm_log.push_back(dqm_word);
      if (byte_valid) byte_log.push_back(byte_out);
      if ((frame_start || dqm_valid || byte_valid) && !en_at_edge) viol++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] s, input logic [15:0] d, input logic [15:0] bs,
                               input logic [31:0] p, input logic g, input int fs, input int dv,
                               input int nb, input logic [31:0] eb, input logic l, input logic [15:0] fc);
      vec_t v;
      v.sync = s; v.dqm = d; v.bs = bs; v.payload = p; v.gap = g;
      v.exp_fs = fs; v.exp_dv = dv; v.exp_nb = nb; v.exp_bytes = eb;
      v.exp_locked = l; v.exp_fc = fc;
      return v;
   endfunction

   task automatic send_bit(input logic b, input logic gap);
      bit_in = b;
      bit_en = 1'b1;
      @(negedge clk);
      if (gap) begin
         bit_en = 1'b0;
         bit_in = ~b;
         @(negedge clk);
      end
   endtask

   task automatic clear_logs();
      fs_cnt = 0;
      byte_log.delete();
      dqm_log.delete();
   endtask

   task automatic check_outputs_reset(input string tag);
      chk({tag, "_dqm_word"}, dqm_word, 32'h0);
      chk({tag, "_dqm_valid"}, dqm_valid, 32'h0);
      chk({tag, "_byte_out"}, byte_out, 32'h0);
      chk({tag, "_byte_valid"}, byte_valid, 32'h0);
      chk({tag, "_frame_start"}, frame_start, 32'h0);
      chk({tag, "_locked"}, locked, 32'h0);
      chk({tag, "_frame_count"}, frame_count, 32'h0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [31:0] eb;
      clear_logs();
      block_size = v.bs;
      for (int i = 31; i >= 0; i--) send_bit(v.sync[i], v.gap);
      block_size = 16'h0003;
      for (int i = 15; i >= 0; i--) send_bit(v.dqm[i], v.gap);
      for (int i = int'(v.bs) - 1; i >= 0; i--) send_bit(v.payload[i], v.gap);
      bit_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_frame_start"}, fs_cnt, v.exp_fs);
      chk({tag, "_dqm_pulses"}, dqm_log.size(), v.exp_dv);
      if (v.exp_dv != 0)
         chk({tag, "_dqm_word"}, (dqm_log.size() > 0) ? {16'h0, dqm_log[0]} : 32'hFFFF_FFFF, v.dqm);
      chk({tag, "_byte_count"}, byte_log.size(), v.exp_nb);
      eb = v.exp_bytes;
      for (int k = 0; k < v.exp_nb; k++)
         chk($sformatf("%s_byte%0d", tag, k),
             (k < byte_log.size()) ? {24'h0, byte_log[k]} : 32'hFFFF_FFFF, eb[31-8*k -: 8]);
      chk({tag, "_locked"}, locked, v.exp_locked);
      chk({tag, "_frame_count"}, frame_count, v.exp_fc);
   endtask

   initial begin
      //             sync  dqm       bs     payload        gap fs dv nb bytes          lock fc
      tbl[0]  = mk(W, 16'h1234, 16'd16, 32'h0000_A5C3, 0, 1, 1, 2, 32'hA5C3_0000, 0, 16'd0);
      tbl[1]  = mk(W, 16'h1234, 16'd16, 32'h0000_A5C3, 0, 1, 1, 2, 32'hA5C3_0000, 1, 16'd1);
      tbl[2]  = mk(W, 16'h5678, 16'd12, 32'h0000_0ABC, 0, 1, 1, 2, 32'hABC0_0000, 1, 16'd2);
      tbl[3]  = mk(W, 16'hBEEF, 16'd0,  32'h0000_0000, 0, 1, 1, 0, 32'h0000_0000, 1, 16'd3);
      tbl[4]  = mk(W, 16'h1234, 16'd16, 32'h0000_A5C3, 1, 1, 1, 2, 32'hA5C3_0000, 1, 16'd4);
      tbl[5]  = mk(W, 16'h0F0F, 16'd32, 32'hFAF3_3400, 0, 1, 1, 4, 32'hFAF3_3400, 1, 16'd5);
      tbl[6]  = mk(C, 16'h1111, 16'd8,  32'h0000_005A, 0, 1, 1, 1, 32'h5A00_0000, 1, 16'd5);
      tbl[7]  = mk(C, 16'h2222, 16'd8,  32'h0000_0096, 0, 1, 1, 1, 32'h9600_0000, 1, 16'd5);
      tbl[8]  = mk(C, 16'h0000, 16'd8,  32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 0, 16'd5);
      tbl[9]  = mk(W, 16'h1234, 16'd16, 32'h0000_A5C3, 0, 1, 1, 2, 32'hA5C3_0000, 0, 16'd5);
      tbl[10] = mk(W, 16'h1234, 16'd16, 32'h0000_A5C3, 0, 1, 1, 2, 32'hA5C3_0000, 1, 16'd6);

      rst        = 1'b1;
      bit_in     = 1'b0;
      bit_en     = 1'b0;
      sync_word  = W;
      block_size = 16'd16;
      @(negedge clk);
      @(negedge clk);
      check_outputs_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Reset in the middle of a payload byte, then reacquire
      clear_logs();
      block_size = 16'd16;
      for (int i = 31; i >= 0; i--) send_bit(W[i], 1'b0);
      for (int i = 15; i >= 0; i--) send_bit(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
      bit_en = 1'b0;
      byte_log.delete();
      rst = 1'b1;
      @(negedge clk);
      check_outputs_reset("midrst");
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_no_partial_byte", byte_log.size(), 32'd0);
      run_vec(mk(W, 16'h1234, 16'd16, 32'h0000_A5C3, 0, 1, 1, 2, 32'hA5C3_0000, 0, 16'd0), "relock0");
      run_vec(mk(W, 16'h1234, 16'd16, 32'h0000_A5C3, 0, 1, 1, 2, 32'hA5C3_0000, 1, 16'd1), "relock1");

      chk("pulse_without_enabled_bit", viol, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dqm_deframer.md
DQM_DEFRAMER -- requirements
Module: dqm_deframer

Interface
REQ-001 Parameter: MISS_LIMIT, 3, consecutive failed sync checks tolerated before lock is dropped.
REQ-002 Parameter: SYNC_WIDTH, 32, sync pattern length in bits (header frame words 0 and 1).
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: bit_in  input  1  serial DQM-framed stream, MSB first.
REQ-006 Port: bit_en  input  1  bit_in is valid and is consumed this cycle.
REQ-007 Port: sync_word  input  32  expected header sync (frame_word_0 in bits 31:16, frame_word_1 in bits 15:0).
REQ-008 Port: block_size  input  16  payload bits per frame; sampled at each frame start.
REQ-009 Port: dqm_word  output  16  last received quality word (header frame word 2).
REQ-010 Port: dqm_valid  output  1  one-cycle pulse when dqm_word updates.
REQ-011 Port: byte_out  output  8  packed payload byte, first-received bit in bit 7.
REQ-012 Port: byte_valid  output  1  one-cycle pulse qualifying byte_out.
REQ-013 Port: frame_start  output  1  one-cycle pulse on sync acceptance.
REQ-014 Port: locked  output  1  frame lock status.
REQ-015 Port: frame_count  output  16  count of frames whose sync check matched; wraps 0xFFFF->0.

Function
REQ-016 All state, counters and shift registers SHALL advance only in cycles with bit_en=1; with bit_en=0 everything holds and all pulse outputs are 0.
REQ-017 FSM states SHALL be SEARCH, DQM, PAYLOAD, CHECK.
REQ-018 SEARCH: shift bit_in into a 32-bit register each accepted bit; when the register including the current bit equals sync_word, go to DQM.
REQ-019 DQM: collect 16 bits; on the 16th, load dqm_word and pulse dqm_valid on the next cycle; go to PAYLOAD, or to CHECK if the latched block_size is 0.
REQ-020 PAYLOAD: consume exactly the latched block_size bits, packing MSB first; byte_valid SHALL pulse the cycle after each 8th bit.
REQ-021 If block_size is not a multiple of 8, the final partial byte SHALL be emitted left-justified, zero-padded, with byte_valid the cycle after the last payload bit.
REQ-022 CHECK: collect 32 bits and compare with sync_word on the 32nd bit.
REQ-023 On a CHECK match: set locked, clear the miss counter, increment frame_count, and go to DQM.
REQ-024 On a CHECK mismatch with miss counter < MISS_LIMIT-1: increment the miss counter and go to DQM (flywheel), leaving locked unchanged.
REQ-025 On a CHECK mismatch with miss counter = MISS_LIMIT-1: clear locked and the miss counter, and go to SEARCH.
REQ-026 frame_start SHALL pulse the cycle after every transition into DQM, whether from a SEARCH match, a CHECK match or a flywheel.
REQ-027 block_size SHALL be latched at each transition into DQM; changes mid-frame SHALL have no effect until the next frame.
REQ-028 Latency: every output pulse SHALL occur exactly one clk after the accepted bit that causes it.
REQ-029 A sync pattern appearing inside DQM or PAYLOAD bits SHALL be ignored.

Reset
REQ-030 On rst: state SEARCH, shift registers 0, dqm_word 0, byte_out 0, frame_count 0, miss counter 0, locked 0, and all pulses 0.
REQ-031 rst mid-frame SHALL abandon the frame without emitting a partial byte.

Structure
REQ-032 Package dqm_pkg SHALL hold the state enumeration, SYNC_WIDTH, DQM_WIDTH=16 and the header length 48.
REQ-033 A sub-module, dqm_bit_packer, SHALL hold the 8-bit MSB-first serial-to-parallel packer with flush-on-last input.

Verification
REQ-034 Scenario: sync_word=0xFAF3_3400, block_size=16, continuous frames with dqm=0x1234 and payload 0xA5C3 -> dqm_valid with 0x1234, bytes 0xA5 then 0xC3, and locked=1 after the second sync.
REQ-035 Scenario: block_size=12, payload bits 0xABC -> bytes 0xAB then 0xC0.
REQ-036 Scenario: MISS_LIMIT=3, corrupt the sync of 2 consecutive frames -> locked stays 1 and frame_start keeps pulsing; corrupt 3 -> locked=0 and state SEARCH after the third CHECK.
REQ-037 Scenario: bit_en toggling 1/0 every cycle -> same bytes and dqm_word as the continuous case, with pulses only one cycle after enabled bits.
REQ-038 Scenario: sync pattern embedded in payload while locked -> no extra frame_start.
REQ-039 Scenario: rst asserted mid-PAYLOAD -> all outputs at reset values next cycle, and relock on the following sync.
